// File: rtl/nqueens_search_engine.sv
`timescale 1ns/1ps
// Backtracking N-queens solver: one placement decision per clock, with a parallel
// safety check of the candidate square against every row already placed.
module nqueens_search_engine #(
    parameter int N    = 8,
    parameter int CW   = (N > 1) ? $clog2(N) : 1,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [N*CW-1:0]     positions,
    output logic [N*N-1:0]      board,
    output logic [CNTW-1:0]     solution_count,
    output logic [CNTW-1:0]     cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEARCH    = 2'd1,
        S_BACKTRACK = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [CW-1:0]     r_q, r_d;
    logic [CW-1:0]     col_q [N];
    logic [CW-1:0]     col_d [N];
    logic [N*CW-1:0]   positions_q, positions_d;
    logic              found_q, found_d;
    logic [CNTW-1:0]   sol_cnt_q, sol_cnt_d;
    logic [CNTW-1:0]   cyc_cnt_q, cyc_cnt_d;

    logic [CW-1:0]     cur_col;
    logic [CW-1:0]     r_inc;
    logic [CW-1:0]     r_dec;
    logic              safe;
    logic              in_search;

    assign cur_col   = col_q[r_q];
    assign r_inc     = r_q + 1'b1;
    assign r_dec     = r_q - 1'b1;
    assign in_search = (state_q == S_SEARCH) || (state_q == S_BACKTRACK);

    // Rows at or above r hold stale columns from earlier branches and are masked out.
    always_comb begin
        safe = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (CW'(k) < r_q) begin
                if (col_q[k] == cur_col) begin
                    safe = 1'b0;
                end
                if (((col_q[k] > cur_col) ? (col_q[k] - cur_col) : (cur_col - col_q[k]))
                    == (r_q - CW'(k))) begin
                    safe = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            r_q         <= '0;
            col_q       <= '{default: '0};
            positions_q <= '0;
            found_q     <= 1'b0;
            sol_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            r_q         <= r_d;
            col_q       <= col_d;
            positions_q <= positions_d;
            found_q     <= found_d;
            sol_cnt_q   <= sol_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        r_d         = r_q;
        col_d       = col_q;
        positions_d = positions_q;
        found_d     = found_q;
        sol_cnt_d   = sol_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;

        // The abort edge itself still counts as a busy clock.
        if (in_search && (cyc_cnt_q != {CNTW{1'b1}})) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_d      = mode;
                        r_d         = '0;
                        col_d[0]    = '0;
                        positions_d = '0;
                        found_d     = 1'b0;
                        sol_cnt_d   = '0;
                        cyc_cnt_d   = '0;
                        state_d     = S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (safe && (r_q != LAST)) begin
                        r_d        = r_inc;
                        col_d[r_inc] = '0;
                    end else begin
                        if (safe) begin
                            for (int k = 0; k < N; k++) begin
                                positions_d[k*CW +: CW] = col_q[k];
                            end
                            found_d = 1'b1;
                            if (sol_cnt_q != {CNTW{1'b1}}) begin
                                sol_cnt_d = sol_cnt_q + 1'b1;
                            end
                            if (!mode_q) begin
                                state_d = S_DONE;
                            end
                        end
                        // In COUNT_ALL a completed board is treated as a rejected candidate.
                        if (!safe || mode_q) begin
                            if (cur_col != LAST) begin
                                col_d[r_q] = cur_col + 1'b1;
                            end else if (r_q == '0) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_BACKTRACK;
                            end
                        end
                    end
                end
                S_BACKTRACK: begin
                    r_d = r_dec;
                    if (col_q[r_dec] != LAST) begin
                        col_d[r_dec] = col_q[r_dec] + 1'b1;
                        state_d      = S_SEARCH;
                    end else if (r_dec == '0) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy           = in_search;
        done           = (state_q == S_DONE);
        found          = found_q;
        positions      = positions_q;
        solution_count = sol_cnt_q;
        cycle_count    = cyc_cnt_q;
        board          = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                board[r*N + c] = found_q && (positions_q[r*CW +: CW] == CW'(c));
            end
        end
    end

endmodule
